ft232h_fifo_emulator: RTL and testbench

Synthesizable device-side model of the FT232H synchronous 245-FIFO port. It drives rxf_n/txe_n and the data bus, and accepts oe_n/rd_n/wr_n/siwu from the FPGA-side USB master. It is used for loopback and self-test of the host-side FIFO master without a physical chip. Its local side has a byte source carrying host-written data and a byte sink carrying data presented to the host, each backed by its own FIFO.

---
 rtl/ft232h_fifo_emulator.sv | 141 ++++++++++++++
 tb/tb_ft232h_fifo_emulator.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft232h_fifo_emulator.sv
// Device-side model of the FT232H synchronous 245-FIFO port for loopback and self-test.
// Two first-word-fall-through byte FIFOs sit behind the host bus and a local byte source/sink.

module ft232h_fifo_emulator_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [LW-1:0] level
);
    localparam int unsigned AW = LW - 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally at DEPTH; callers gate push/pop against full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = (level == '0) ? 8'h00 : mem[rd_ptr];
endmodule

module ft232h_fifo_emulator #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = 5
) (
    input  logic          usb_clock,
    input  logic          reset_n,
    input  logic [7:0]    usb_data_in,
    output logic [7:0]    usb_data_out,
    output logic          usb_data_oe,
    input  logic          usb_oe_n,
    input  logic          usb_rd_n,
    input  logic          usb_wr_n,
    input  logic          usb_siwu,
    output logic          usb_rxf_n,
    output logic          usb_txe_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] rx_level,
    output logic [LW-1:0] tx_level,
    output logic          siwu_pulse,
    output logic          err_underrun,
    output logic          err_overrun,
    output logic          err_proto,
    input  logic          clear_err
);
    logic oe_q;
    logic siwu_q;
    logic rx_push;
    logic rx_pop;
    logic tx_push;
    logic tx_pop;
    logic set_underrun;
    logic set_overrun;
    logic set_proto;

    // Handshake flags decode from the registered levels.
    assign usb_rxf_n   = (rx_level == '0);
    assign usb_txe_n   = (tx_level == LW'(DEPTH));
    assign in_ready    = (rx_level < LW'(DEPTH));
    assign out_valid   = (tx_level != '0);
    assign usb_data_oe = !usb_oe_n;
    assign siwu_pulse  = siwu_q && !usb_siwu;

    // A master read needs output enable held since the previous cycle.
    assign rx_pop  = !usb_rd_n && !usb_oe_n && oe_q && !usb_rxf_n;
    assign rx_push = in_valid && in_ready;
    assign tx_push = !usb_wr_n && !usb_txe_n && usb_oe_n;
    assign tx_pop  = out_valid && out_ready;

    assign set_underrun = !usb_rd_n && usb_rxf_n;
    assign set_overrun  = !usb_wr_n && usb_txe_n;
    assign set_proto    = (!usb_rd_n && (!oe_q || usb_oe_n)) || (!usb_wr_n && !usb_oe_n);

    ft232h_fifo_emulator_fifo #(.DEPTH(DEPTH), .LW(LW)) u_rx_fifo (
        .clk       (usb_clock),
        .rst_n     (reset_n),
        .push      (rx_push),
        .push_data (in_data),
        .pop       (rx_pop),
        .head      (usb_data_out),
        .level     (rx_level)
    );

    ft232h_fifo_emulator_fifo #(.DEPTH(DEPTH), .LW(LW)) u_tx_fifo (
        .clk       (usb_clock),
        .rst_n     (reset_n),
        .push      (tx_push),
        .push_data (usb_data_in),
        .pop       (tx_pop),
        .head      (out_data),
        .level     (tx_level)
    );

    // Bus history registers and sticky errors; clear wins over a same-cycle set.
    always_ff @(posedge usb_clock or negedge reset_n) begin
        if (!reset_n) begin
            oe_q         <= 1'b0;
            siwu_q       <= 1'b1;
            err_underrun <= 1'b0;
            err_overrun  <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            oe_q   <= !usb_oe_n;
            siwu_q <= usb_siwu;
            if (clear_err) begin
                err_underrun <= 1'b0;
                err_overrun  <= 1'b0;
                err_proto    <= 1'b0;
            end else begin
                err_underrun <= err_underrun || set_underrun;
                err_overrun  <= err_overrun  || set_overrun;
                err_proto    <= err_proto    || set_proto;
            end
        end
    end
endmodule

// File: tb/tb_ft232h_fifo_emulator.sv
// Self-checking bench for ft232h_fifo_emulator: vector table, corner sequences, random vs queue model.

module tb_ft232h_fifo_emulator;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 5;

    logic          usb_clock = 1'b0;
    logic          reset_n;
    logic [7:0]    usb_data_in;
    logic [7:0]    usb_data_out;
    logic          usb_data_oe;
    logic          usb_oe_n;
    logic          usb_rd_n;
    logic          usb_wr_n;
    logic          usb_siwu;
    logic          usb_rxf_n;
    logic          usb_txe_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] rx_level;
    logic [LW-1:0] tx_level;
    logic          siwu_pulse;
    logic          err_underrun;
    logic          err_overrun;
    logic          err_proto;
    logic          clear_err;

    ft232h_fifo_emulator #(.DEPTH(DEPTH), .LW(LW)) dut (
        .usb_clock    (usb_clock),
        .reset_n      (reset_n),
        .usb_data_in  (usb_data_in),
        .usb_data_out (usb_data_out),
        .usb_data_oe  (usb_data_oe),
        .usb_oe_n     (usb_oe_n),
        .usb_rd_n     (usb_rd_n),
        .usb_wr_n     (usb_wr_n),
        .usb_siwu     (usb_siwu),
        .usb_rxf_n    (usb_rxf_n),
        .usb_txe_n    (usb_txe_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rx_level     (rx_level),
        .tx_level     (tx_level),
        .siwu_pulse   (siwu_pulse),
        .err_underrun (err_underrun),
        .err_overrun  (err_overrun),
        .err_proto    (err_proto),
        .clear_err    (clear_err)
    );

    always #5 usb_clock = ~usb_clock;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       oe_n;
        logic       rd_n;
        logic       wr_n;
        logic [7:0] dq;
        logic       clr;
        logic [4:0] e_rxl;
        logic [4:0] e_txl;
        logic       e_rxf_n;
        logic [7:0] e_dout;
        logic       e_ov;
        logic       e_eu;
        logic       e_eo;
        logic       e_ep;
    } vec_t;

    vec_t tbl [11];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference state for the random phase
    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    bit   m_oeq, m_siwuq, m_eu, m_eo, m_ep;
    bit   r_oe, r_rd, r_wr, r_iv, r_ordy, r_siwu, r_clr;
    logic [7:0] r_id, r_dq;
    bit   m_rxf_n, m_txe_n, m_rpop, m_rpush, m_tpush, m_tpop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge usb_clock);
        #1;
    endtask

    task automatic set_idle();
        usb_data_in = 8'h00;
        usb_oe_n    = 1'b1;
        usb_rd_n    = 1'b1;
        usb_wr_n    = 1'b1;
        usb_siwu    = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        clear_err   = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic push_rx(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 5'd1, 5'd0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 5'd2, 5'd0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 5'd2, 5'd0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 5'd1, 5'd0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 5'd0, 5'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 5'd0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 5'd0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 5'd0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        set_idle();
        reset_n = 1'b0;
        #2;
        chk("rst_rx_level", 32'(rx_level), 0);
        chk("rst_tx_level", 32'(tx_level), 0);
        chk("rst_rxf_n", 32'(usb_rxf_n), 1);
        chk("rst_txe_n", 32'(usb_txe_n), 0);
        chk("rst_data_oe", 32'(usb_data_oe), 0);
        chk("rst_data_out", 32'(usb_data_out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_siwu_pulse", 32'(siwu_pulse), 0);
        chk("rst_errors", 32'({err_underrun, err_overrun, err_proto}), 0);
        do_reset();

        // Vector table
        for (int v = 0; v < 11; v++) begin
            in_valid = tbl[v].iv;   in_data  = tbl[v].id;  out_ready = tbl[v].ordy;
            usb_oe_n = tbl[v].oe_n; usb_rd_n = tbl[v].rd_n; usb_wr_n = tbl[v].wr_n;
            usb_data_in = tbl[v].dq; clear_err = tbl[v].clr;
            step();
            chk($sformatf("tbl%0d_rx_level", v), 32'(rx_level), 32'(tbl[v].e_rxl));
            chk($sformatf("tbl%0d_tx_level", v), 32'(tx_level), 32'(tbl[v].e_txl));
            chk($sformatf("tbl%0d_rxf_n", v), 32'(usb_rxf_n), 32'(tbl[v].e_rxf_n));
            chk($sformatf("tbl%0d_data_out", v), 32'(usb_data_out), 32'(tbl[v].e_dout));
            chk($sformatf("tbl%0d_out_valid", v), 32'(out_valid), 32'(tbl[v].e_ov));
            if (tbl[v].e_ov) chk($sformatf("tbl%0d_out_data", v), 32'(out_data), 32'(tbl[v].dq));
            chk($sformatf("tbl%0d_errs", v), 32'({err_underrun, err_overrun, err_proto}),
                32'({tbl[v].e_eu, tbl[v].e_eo, tbl[v].e_ep}));
        end
        set_idle();

        // siwu falling edge pulse
        usb_siwu = 1'b0;
        #1 chk("siwu_pulse_fall", 32'(siwu_pulse), 1);
        step();
        chk("siwu_pulse_held_low", 32'(siwu_pulse), 0);
        usb_siwu = 1'b1;
        #1 chk("siwu_pulse_rise", 32'(siwu_pulse), 0);

        // Loopback order
        do_reset();
        push_rx(16, 8'h00);
        chk("lb_full_level", 32'(rx_level), 16);
        chk("lb_in_ready", 32'(in_ready), 0);
        usb_oe_n = 1'b0;
        step();
        usb_rd_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1 chk($sformatf("lb_byte%0d", i), 32'(usb_data_out), 32'(i));
            step();
        end
        usb_rd_n = 1'b1;
        chk("lb_rxf_n_after", 32'(usb_rxf_n), 1);
        chk("lb_level_after", 32'(rx_level), 0);
        set_idle();

        // Host write to full
        do_reset();
        for (int k = 0; k < 17; k++) begin
            usb_wr_n = 1'b0;
            usb_data_in = 8'hA0 + 8'(k);
            step();
            if (k == 15) begin
                chk("wf_txe_n_full", 32'(usb_txe_n), 1);
                chk("wf_no_overrun_yet", 32'(err_overrun), 0);
            end
        end
        usb_wr_n = 1'b1;
        chk("wf_overrun", 32'(err_overrun), 1);
        chk("wf_level", 32'(tx_level), 16);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("wf_valid%0d", k), 32'(out_valid), 1);
            chk($sformatf("wf_data%0d", k), 32'(out_data), 32'(8'hA0 + 8'(k)));
            step();
        end
        chk("wf_drained", 32'(out_valid), 0);
        set_idle();

        // Protocol violation: oe_n rises the cycle rd_n falls
        do_reset();
        push_rx(3, 8'h40);
        usb_oe_n = 1'b0;
        step();
        usb_oe_n = 1'b1;
        usb_rd_n = 1'b0;
        step();
        usb_rd_n = 1'b1;
        chk("pv_level", 32'(rx_level), 3);
        chk("pv_proto", 32'(err_proto), 1);
        chk("pv_underrun", 32'(err_underrun), 0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("pv_cleared", 32'(err_proto), 0);

        // Underrun
        do_reset();
        usb_oe_n = 1'b0;
        step();
        usb_rd_n = 1'b0;
        step();
        chk("ur_underrun", 32'(err_underrun), 1);
        chk("ur_proto", 32'(err_proto), 0);
        chk("ur_data_out", 32'(usb_data_out), 0);
        chk("ur_data_oe", 32'(usb_data_oe), 1);
        set_idle();

        // Full rx with simultaneous local push and master pop
        do_reset();
        push_rx(16, 8'h00);
        usb_oe_n = 1'b0;
        step();
        usb_rd_n = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step();
        usb_rd_n = 1'b1;
        in_valid = 1'b0;
        chk("sim_level", 32'(rx_level), 15);
        chk("sim_in_ready", 32'(in_ready), 1);
        usb_rd_n = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1 chk($sformatf("sim_byte%0d", i), 32'(usb_data_out), 32'(i + 1));
            step();
        end
        usb_rd_n = 1'b1;
        chk("sim_empty", 32'(rx_level), 0);
        set_idle();

        // Reset mid-burst
        do_reset();
        push_rx(8, 8'h80);
        usb_oe_n = 1'b0;
        step();
        usb_rd_n = 1'b0;
        step();
        reset_n  = 1'b0;
        usb_oe_n = 1'b1;
        usb_rd_n = 1'b1;
        #1;
        chk("mr_rx_level", 32'(rx_level), 0);
        chk("mr_rxf_n", 32'(usb_rxf_n), 1);
        chk("mr_txe_n", 32'(usb_txe_n), 0);
        chk("mr_data_out", 32'(usb_data_out), 0);
        chk("mr_data_oe", 32'(usb_data_oe), 0);
        chk("mr_in_ready", 32'(in_ready), 1);
        step();
        reset_n = 1'b1;
        step();
        chk("mr_rel_rxf_n", 32'(usb_rxf_n), 1);
        chk("mr_rel_txe_n", 32'(usb_txe_n), 0);

        // Random traffic against a queue-based model
        do_reset();
        rxq.delete(); txq.delete();
        m_oeq = 0; m_siwuq = 1; m_eu = 0; m_eo = 0; m_ep = 0;
        for (int c = 0; c < 500; c++) begin
            r_oe   = ($urandom_range(99) < 50);
            r_rd   = ($urandom_range(99) < 55);
            r_wr   = ($urandom_range(99) < 60);
            r_iv   = ($urandom_range(99) < 50);
            r_ordy = ($urandom_range(99) < 40);
            r_siwu = ($urandom_range(99) < 80);
            r_clr  = ($urandom_range(99) < 5);
            r_id   = 8'($urandom);
            r_dq   = 8'($urandom);
            usb_oe_n = r_oe; usb_rd_n = r_rd; usb_wr_n = r_wr; usb_siwu = r_siwu;
            in_valid = r_iv; in_data = r_id; out_ready = r_ordy; usb_data_in = r_dq; clear_err = r_clr;
            #1;
            m_rxf_n = (rxq.size() == 0);
            m_txe_n = (txq.size() == DEPTH);
            chk("rnd_rx_level", 32'(rx_level), 32'(rxq.size()));
            chk("rnd_tx_level", 32'(tx_level), 32'(txq.size()));
            chk("rnd_rxf_n", 32'(usb_rxf_n), 32'(m_rxf_n));
            chk("rnd_txe_n", 32'(usb_txe_n), 32'(m_txe_n));
            chk("rnd_data_out", 32'(usb_data_out), m_rxf_n ? 0 : 32'(rxq[0]));
            chk("rnd_data_oe", 32'(usb_data_oe), 32'(!r_oe));
            chk("rnd_in_ready", 32'(in_ready), 32'(rxq.size() < DEPTH));
            chk("rnd_out_valid", 32'(out_valid), 32'(txq.size() != 0));
            if (txq.size() != 0) chk("rnd_out_data", 32'(out_data), 32'(txq[0]));
            chk("rnd_siwu_pulse", 32'(siwu_pulse), 32'(m_siwuq && !r_siwu));
            chk("rnd_errs", 32'({err_underrun, err_overrun, err_proto}), 32'({m_eu, m_eo, m_ep}));
            m_rpop  = !r_rd && !r_oe && m_oeq && !m_rxf_n;
            m_rpush = r_iv && (rxq.size() < DEPTH);
            m_tpush = !r_wr && !m_txe_n && r_oe;
            m_tpop  = r_ordy && (txq.size() != 0);
            if (r_clr) begin
                m_eu = 0; m_eo = 0; m_ep = 0;
            end else begin
                m_eu = m_eu | (!r_rd && m_rxf_n);
                m_eo = m_eo | (!r_wr && m_txe_n);
                m_ep = m_ep | (!r_rd && (!m_oeq || r_oe)) | (!r_wr && !r_oe);
            end
            step();
            if (m_rpop)  void'(rxq.pop_front());
            if (m_rpush) rxq.push_back(r_id);
            if (m_tpop)  void'(txq.pop_front());
            if (m_tpush) txq.push_back(r_dq);
            m_oeq   = !r_oe;
            m_siwuq = r_siwu;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
